pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with carry-in, status flags and valid/ready flow control. It replaces the single-cycle ripple adder in the datapath wherever wide operands or clock targets make a full-width ripple path too slow. Operands are split into equal slices. Each pipeline stage resolves one slice and passes its carry forward, giving one result per cycle at a latency of STAGES cycles.

---
 rtl/pipelined_adder.sv | 125 ++++++++++++
 tb/tb_pipelined_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: a two's-complement adder/subtractor split into STAGES
// equal slices. Each stage resolves one slice and hands its carry to the
// next, giving one result per cycle at a latency of STAGES cycles.
//
// Handshake: a beat enters on a rising edge where i_in_valid && o_in_ready,
// and leaves on a rising edge where o_out_valid && i_out_ready. The stall is
// global: when the output holds a beat the consumer refuses, every stage
// freezes and o_in_ready drops in the same cycle.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    // Guarded so an illegal STAGES reaches the error below instead of a divide by zero.
    localparam int SW = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    if ((STAGES < 1) || (((STAGES > 0) ? (WIDTH % STAGES) : 1) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // Per-stage registers: operands ride along until their slice is consumed,
    // and finished result slices ride along so a beat exits all at once.
    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_c     [STAGES];
    logic             r_ovf;
    logic             r_zero;

    // Inputs seen by each stage (stage 0 takes the ports, others the previous stage).
    logic             w_v_in   [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_sum_in [STAGES];
    logic             w_c_in   [STAGES];
    logic [SW:0]      w_slice  [STAGES];
    logic [WIDTH-1:0] w_sum_nx [STAGES];
    logic             w_stall;
    logic             w_ovf;
    logic             w_zero;

    assign w_stall     = r_valid[STAGES-1] && !i_out_ready;
    assign o_in_ready  = !w_stall;
    assign o_out_valid = r_valid[STAGES-1];
    assign o_res       = r_sum[STAGES-1];
    assign o_cout      = r_c[STAGES-1];
    assign o_ovf       = r_ovf;
    assign o_zero      = r_zero;

    // Route each stage's inputs; subtraction inverts B and the carry-in up front.
    always_comb begin
        w_v_in[0]   = i_in_valid;
        w_a_in[0]   = i_op1;
        w_b_in[0]   = i_sub ? ~i_op2 : i_op2;
        w_c_in[0]   = i_cin ^ i_sub;
        w_sum_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_v_in[k]   = r_valid[k-1];
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_c_in[k]   = r_c[k-1];
            w_sum_in[k] = r_sum[k-1];
        end
    end

    // Slice adders: stage k adds slice k and merges it into the partial result.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k] = {1'b0, w_a_in[k][k*SW +: SW]}
                       + {1'b0, w_b_in[k][k*SW +: SW]}
                       + {{SW{1'b0}}, w_c_in[k]};
            w_sum_nx[k] = w_sum_in[k];
            w_sum_nx[k][k*SW +: SW] = w_slice[k][SW-1:0];
        end
    end

    // Status flags are formed in the last stage so they register alongside the result.
    always_comb begin
        w_ovf  = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1])
              && (w_sum_nx[STAGES-1][WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);
        w_zero = ~|w_sum_nx[STAGES-1];
    end

    // Pipeline advance: bubbles move like data; everything freezes on a stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_c[k]     <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_v_in[k];
                r_a[k]     <= w_a_in[k];
                r_b[k]     <= w_b_in[k];
                r_sum[k]   <= w_sum_nx[k];
                r_c[k]     <= w_slice[k][SW];
            end
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=32, STAGES=4): directed vectors with
// hand-computed results, a random backpressure stream checked against a
// small reference model, and reset/latency checks.
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        i_cin;
    logic        i_sub;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_res;
    logic        o_cout;
    logic        o_ovf;
    logic        o_zero;

    // expected {res, cout, ovf, zero}
    logic [34:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_op1       (i_op1),
        .i_op2       (i_op2),
        .i_cin       (i_cin),
        .i_sub       (i_sub),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_res       (o_res),
        .o_cout      (o_cout),
        .o_ovf       (o_ovf),
        .o_zero      (o_zero)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        logic [31:0] eb;
        logic [32:0] t;
        logic        v;
        eb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, eb} + {32'b0, c ^ s};
        v  = (a[31] == eb[31]) && (t[31] != a[31]);
        return {t[31:0], t[32], v, (t[31:0] == 32'h0)};
    endfunction

    // scoreboard monitor: compares every output transfer with the queue head
    always @(negedge clk) begin
        if (rst_n && o_out_valid && i_out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got res %0h expected no output", o_res);
            end else begin
                check("result", {29'b0, o_res, o_cout, o_ovf, o_zero}, {29'b0, exp_q.pop_front()});
            end
        end
    end

    // driver: called at a rising edge; returns at the accepting rising edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, input logic [34:0] e);
        bit ok;
        int n;
        #1;
        i_in_valid = 1'b1;
        i_op1 = a;
        i_op2 = b;
        i_cin = c;
        i_sub = s;
        ok = 0;
        n  = 0;
        do begin
            @(negedge clk);
            ok = o_in_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 100);
        if (ok) exp_q.push_back(e);
        else check("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic idle(input int cycles);
        #1;
        i_in_valid = 1'b0;
        for (int i = 0; i < cycles; i++) @(posedge clk);
    endtask

    // sends one beat alone and counts edges until out_valid (acceptance edge = 1)
    task automatic latency_test(input logic [31:0] a, input logic [31:0] b, input logic c,
                                input logic s, input logic [34:0] e);
        int n;
        send(a, b, c, s, e);
        #1;
        i_in_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_out_valid && n == 0) n = i;
        end
        check("latency", 64'(n), 64'd4);
        @(posedge clk);
    endtask

    task automatic stall_proc();
        int          n;
        logic [35:0] held;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_out_valid && n < 50);
        check("stall_found_output", 64'(o_out_valid), 64'd1);
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready_low", 64'(o_in_ready), 64'd0);
            if (i == 0) held = {o_out_valid, o_res, o_cout, o_ovf, o_zero};
            else check("stall_outputs_stable", 64'({o_out_valid, o_res, o_cout, o_ovf, o_zero}), 64'(held));
            @(posedge clk);
        end
        #1;
        i_out_ready = 1'b1;
        @(negedge clk);
        check("stall_in_ready_back", 64'(o_in_ready), 64'd1);
    endtask

    task automatic stream_proc();
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            send(a, b, c, s, model(a, b, c, s));
        end
        #1;
        i_in_valid = 1'b0;
    endtask

    initial begin
        int n_before;
        int n;
        rst_n       = 1'b0;
        i_in_valid  = 1'b1;
        i_op1       = 32'h1234_5678;
        i_op2       = 32'h0F0F_0F0F;
        i_cin       = 1'b1;
        i_sub       = 1'b0;
        i_out_ready = 1'b1;

        // reset held with input offered
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(o_out_valid), 64'd0);
        check("reset_res", 64'(o_res), 64'd0);
        check("reset_flags", 64'({o_cout, o_ovf, o_zero}), 64'd0);
        check("reset_in_ready", 64'(o_in_ready), 64'd1);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check("no_output_after_reset", 64'(n_out), 64'd0);

        // full carry chain, with latency
        latency_test(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});

        // signed overflow and borrow vectors, back to back
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, {32'h0000_0001, 1'b1, 1'b0, 1'b0});
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
        idle(8);

        // backpressure during a random stream
        fork
            stream_proc();
            stall_proc();
        join
        idle(12);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // reset mid-flight
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, {32'h0000_0030, 1'b0, 1'b0, 1'b0});
        send(32'h0000_0011, 32'h0000_0021, 1'b0, 1'b0, {32'h0000_0032, 1'b0, 1'b0, 1'b0});
        send(32'h0000_0012, 32'h0000_0022, 1'b0, 1'b0, {32'h0000_0034, 1'b0, 1'b0, 1'b0});
        #1;
        i_in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        n_before = n_out;
        #1;
        check("midflight_out_valid", 64'(o_out_valid), 64'd0);
        check("midflight_in_ready", 64'(o_in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check("midflight_discarded", 64'(n_out - n_before), 64'd0);
        latency_test(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, {32'hEFBE_D000, 1'b0, 1'b0, 1'b0});

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
